ahb3lite_req_arbiter: RTL and testbench

Round-robin arbiter and AHB3-Lite single-transfer master that shares one `ahb3lite_apb_bridge` slave port between NUM_REQ on-chip requesters. Each requester posts one read or write command. The block grants it, runs exactly one NONSEQ SINGLE transfer into the bridge, waits out bridge wait states, and returns read data and error status with a one-cycle done pulse. It sits on the HCLK side, directly in front of the bridge's AHB slave port.

---
 rtl/ahb3lite_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/ahb3lite_req_arbiter.sv | 120 ++++++++++++
 tb/tb_ahb3lite_req_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_arb_pkg.sv
// Shared constants and state encoding for the AHB3-Lite request arbiter.
package ahb3lite_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from last+1 upward, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int unsigned IW = $clog2(N);

  int            k;
  logic [IW-1:0] kk;

  // First requester found after the previous winner takes the grant.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = 1; i <= int'(N); i++) begin
      k  = (int'(last) + i) % int'(N);
      kk = k[IW-1:0];
      if (!valid && req[kk]) begin
        valid     = 1'b1;
        grant[kk] = 1'b1;
        idx       = kk;
      end
    end
  end

endmodule

// File: rtl/ahb3lite_req_arbiter.sv
// Round-robin arbiter that runs one NONSEQ SINGLE AHB3-Lite transfer per grant.
module ahb3lite_req_arbiter
  import ahb3lite_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*HADDR_SIZE-1:0] req_addr_i,
  input  logic [NUM_REQ*HDATA_SIZE-1:0] req_wdata_i,
  input  logic [NUM_REQ*3-1:0]          req_size_i,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [HDATA_SIZE-1:0]         rdata_o,
  output logic                          err_o,
  output logic                          HSEL,
  output logic                          HWRITE,
  output logic [1:0]                    HTRANS,
  output logic [HADDR_SIZE-1:0]         HADDR,
  output logic [HDATA_SIZE-1:0]         HWDATA,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [3:0]                    HPROT,
  output logic                          HREADY,
  input  logic [HDATA_SIZE-1:0]         HRDATA,
  input  logic                          HREADYOUT,
  input  logic                          HRESP
);

  localparam int IW = $clog2(NUM_REQ);

  state_t                  state;
  logic [IW-1:0]           last_grant;
  logic [NUM_REQ-1:0]      grant_oh;
  logic [NUM_REQ-1:0]      pick_oh;
  logic [IW-1:0]           pick_idx;
  logic                    pick_valid;
  logic [HADDR_SIZE-1:0]   sel_addr;
  logic [HDATA_SIZE-1:0]   sel_wdata;
  logic [2:0]              sel_size;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req  (req_i),
    .last (last_grant),
    .grant(pick_oh),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  // Single slave: the bus ready is the slave's own ready.
  assign HREADY = HREADYOUT;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_DEFAULT;

  // Payload of the current round-robin winner.
  always_comb begin
    sel_addr  = req_addr_i[int'(pick_idx)*HADDR_SIZE +: HADDR_SIZE];
    sel_wdata = req_wdata_i[int'(pick_idx)*HDATA_SIZE +: HDATA_SIZE];
    sel_size  = req_size_i[int'(pick_idx)*3 +: 3];
  end

  // Transfer FSM; the registered AHB outputs double as the payload latch.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ST_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      grant_oh   <= '0;
      HSEL       <= 1'b0;
      HTRANS     <= HTRANS_IDLE;
      HADDR      <= '0;
      HWDATA     <= '0;
      HWRITE     <= 1'b0;
      HSIZE      <= HSIZE_WORD;
      done_o     <= '0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
    end else begin
      done_o <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            last_grant <= pick_idx;
            grant_oh   <= pick_oh;
            HSEL       <= 1'b1;
            HTRANS     <= HTRANS_NONSEQ;
            HADDR      <= sel_addr;
            HWDATA     <= sel_wdata;
            HWRITE     <= req_write_i[pick_idx];
            HSIZE      <= sel_size;
            state      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (HREADYOUT) begin
            HSEL   <= 1'b0;
            HTRANS <= HTRANS_IDLE;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          // First cycle of a two-cycle error response has HREADYOUT low: just wait.
          if (HREADYOUT) begin
            if (!HWRITE) rdata_o <= HRDATA;
            err_o  <= HRESP;
            done_o <= grant_oh;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_req_arbiter.sv
// Directed self-checking bench for ahb3lite_req_arbiter.
module tb_ahb3lite_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [N-1:0]      req_i, req_write_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_wdata_i;
  logic [N*3-1:0]    req_size_i;
  logic [N-1:0]      done_o;
  logic [DW-1:0]     rdata_o;
  logic              err_o;
  logic              HSEL, HWRITE, HREADY;
  logic [1:0]        HTRANS;
  logic [AW-1:0]     HADDR;
  logic [DW-1:0]     HWDATA;
  logic [2:0]        HSIZE, HBURST;
  logic [3:0]        HPROT;
  logic [DW-1:0]     HRDATA;
  logic              HREADYOUT, HRESP;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  ahb3lite_req_arbiter #(
    .NUM_REQ(N), .HADDR_SIZE(AW), .HDATA_SIZE(DW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_i(req_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
    .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .HSEL(HSEL), .HWRITE(HWRITE), .HTRANS(HTRANS), .HADDR(HADDR), .HWDATA(HWDATA),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_req(input int k, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] sz);
    req_write_i[k]          = wr;
    req_addr_i[k*AW +: AW]  = addr;
    req_wdata_i[k*DW +: DW] = wd;
    req_size_i[k*3 +: 3]    = sz;
    req_i[k]                = 1'b1;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    int w;
    ok = 1'b0;
    w  = 0;
    while (!ok && w < max_cyc) begin
      step();
      w++;
      if (done_o != '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    step(); step();
    n_cmp++; if (HSEL !== 1'b0) begin n_fail++; $display("FAIL rst_hsel: got %b want 0", HSEL); end
    n_cmp++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %b want 00", HTRANS); end
    n_cmp++; if (HADDR !== 32'h0) begin n_fail++; $display("FAIL rst_haddr: got %h want 0", HADDR); end
    n_cmp++; if (HWDATA !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata: got %h want 0", HWDATA); end
    n_cmp++; if (HWRITE !== 1'b0) begin n_fail++; $display("FAIL rst_hwrite: got %b want 0", HWRITE); end
    n_cmp++; if (HSIZE !== 3'b010) begin n_fail++; $display("FAIL rst_hsize: got %b want 010", HSIZE); end
    n_cmp++; if (HBURST !== 3'b000) begin n_fail++; $display("FAIL rst_hburst: got %b want 000", HBURST); end
    n_cmp++; if (HPROT !== 4'b0011) begin n_fail++; $display("FAIL rst_hprot: got %b want 0011", HPROT); end
    n_cmp++; if (done_o !== 4'b0000) begin n_fail++; $display("FAIL rst_done: got %b want 0000", done_o); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_o); end
    HREADYOUT = 1'b0; #1;
    n_cmp++; if (HREADY !== 1'b0) begin n_fail++; $display("FAIL rst_hready_lo: got %b want 0", HREADY); end
    HREADYOUT = 1'b1; #1;
    n_cmp++; if (HREADY !== 1'b1) begin n_fail++; $display("FAIL rst_hready_hi: got %b want 1", HREADY); end
    step();
    HRESETn = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    HRDATA = 32'h0000_1234;
    set_req(0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 3'b010);
    step();  // grant edge T; cycle T+1 is the address phase
    n_cmp++; if (HTRANS !== 2'b10) begin n_fail++; $display("FAIL wr_htrans_addr: got %b want 10", HTRANS); end
    n_cmp++; if (HSEL !== 1'b1) begin n_fail++; $display("FAIL wr_hsel_addr: got %b want 1", HSEL); end
    n_cmp++; if (HADDR !== 32'h10) begin n_fail++; $display("FAIL wr_haddr: got %h want 10", HADDR); end
    n_cmp++; if (HWRITE !== 1'b1) begin n_fail++; $display("FAIL wr_hwrite: got %b want 1", HWRITE); end
    n_cmp++; if (HSIZE !== 3'b010) begin n_fail++; $display("FAIL wr_hsize: got %b want 010", HSIZE); end
    // Payload changes after the grant must not leak into the transfer.
    req_addr_i[31:0]  = 32'hDEAD_BEEF;
    req_wdata_i[31:0] = 32'h0;
    step();  // data phase T+2
    n_cmp++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL wr_htrans_data: got %b want 00", HTRANS); end
    n_cmp++; if (HSEL !== 1'b0) begin n_fail++; $display("FAIL wr_hsel_data: got %b want 0", HSEL); end
    n_cmp++; if (HWDATA !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL wr_hwdata: got %h want a5a5a5a5", HWDATA); end
    n_cmp++; if (HADDR !== 32'h10) begin n_fail++; $display("FAIL wr_haddr_hold: got %h want 10", HADDR); end
    n_cmp++; if (done_o !== 4'b0000) begin n_fail++; $display("FAIL wr_done_early: got %b want 0000", done_o); end
    step();  // T+3
    n_cmp++; if (done_o !== 4'b0001) begin n_fail++; $display("FAIL wr_done: got %b want 0001", done_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", err_o); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_kept: got %h want 0", rdata_o); end
    req_i = '0;
    step();
    n_cmp++; if (done_o !== 4'b0000) begin n_fail++; $display("FAIL wr_done_pulse: got %b want 0000", done_o); end
  endtask

  task automatic test_read_wait();
    set_req(2, 1'b0, 32'h0000_0040, 32'h0, 3'b001);
    step();  // T
    n_cmp++; if (HTRANS !== 2'b10) begin n_fail++; $display("FAIL rd_htrans: got %b want 10", HTRANS); end
    n_cmp++; if (HADDR !== 32'h40) begin n_fail++; $display("FAIL rd_haddr: got %h want 40", HADDR); end
    n_cmp++; if (HSIZE !== 3'b001) begin n_fail++; $display("FAIL rd_hsize: got %b want 001", HSIZE); end
    n_cmp++; if (HWRITE !== 1'b0) begin n_fail++; $display("FAIL rd_hwrite: got %b want 0", HWRITE); end
    step();  // T+1 edge -> data phase
    HREADYOUT = 1'b0;
    HRDATA    = 32'h0000_005A;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (done_o !== 4'b0000) begin n_fail++; $display("FAIL rd_done_wait%0d: got %b want 0000", i, done_o); end
    end
    HREADYOUT = 1'b1;
    step();  // cycle T+6
    n_cmp++; if (done_o !== 4'b0100) begin n_fail++; $display("FAIL rd_done: got %b want 0100", done_o); end
    n_cmp++; if (rdata_o !== 32'h5A) begin n_fail++; $display("FAIL rd_rdata: got %h want 5a", rdata_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", err_o); end
    req_i  = '0;
    HRDATA = '0;
    step();
  endtask

  task automatic test_round_robin();
    int          order [5];
    int          prev;
    bit          ok;
    logic [3:0]  exp_oh;
    order = '{0, 1, 2, 3, 0};
    prev  = 0;
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 32'(k * 4), 32'h0, 3'b010);
    for (int n = 0; n < 5; n++) begin
      wait_done(12, ok);
      exp_oh = 4'b0001 << order[n];
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rr_timeout%0d: got none want done", n); end
      n_cmp++; if (done_o !== exp_oh) begin n_fail++; $display("FAIL rr_order%0d: got %b want %b", n, done_o, exp_oh); end
      if (n > 0) begin
        n_cmp++; if (cyc - prev !== 4) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d want 4", n, cyc - prev); end
      end
      prev = cyc;
    end
    req_i = '0;
    step();
  endtask

  task automatic test_error();
    bit ok;
    HRESP = 1'b0;
    set_req(1, 1'b0, 32'h0000_0080, 32'h0, 3'b010);
    step(); step();  // now in data phase
    HREADYOUT = 1'b0;
    HRESP     = 1'b1;
    step();
    n_cmp++; if (done_o !== 4'b0000) begin n_fail++; $display("FAIL err_first_cycle: got %b want 0000", done_o); end
    HREADYOUT = 1'b1;
    step();
    n_cmp++; if (done_o !== 4'b0010) begin n_fail++; $display("FAIL err_done: got %b want 0010", done_o); end
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", err_o); end
    req_i = '0;
    HRESP = 1'b0;
    step();
    set_req(2, 1'b1, 32'h0000_00C0, 32'h0000_0011, 3'b010);
    wait_done(8, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL err_next_timeout: got none want done"); end
    n_cmp++; if (done_o !== 4'b0100) begin n_fail++; $display("FAIL err_next_done: got %b want 0100", done_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_next_flag: got %b want 0", err_o); end
    req_i = '0;
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_req(3, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
    step(); step();
    HREADYOUT = 1'b0;
    step();  // stalled in data phase
    #2;
    HRESETn = 1'b0;
    #1;
    n_cmp++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL mid_htrans: got %b want 00", HTRANS); end
    n_cmp++; if (HSEL !== 1'b0) begin n_fail++; $display("FAIL mid_hsel: got %b want 0", HSEL); end
    n_cmp++; if (done_o !== 4'b0000) begin n_fail++; $display("FAIL mid_done: got %b want 0000", done_o); end
    n_cmp++; if (HADDR !== 32'h0) begin n_fail++; $display("FAIL mid_haddr: got %h want 0", HADDR); end
    set_req(1, 1'b0, 32'h0000_0020, 32'h0, 3'b010);
    HREADYOUT = 1'b1;
    step(); step();
    n_cmp++; if (done_o !== 4'b0000) begin n_fail++; $display("FAIL mid_done_held: got %b want 0000", done_o); end
    HRESETn = 1'b1;
    wait_done(8, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL mid_first_timeout: got none want done"); end
    n_cmp++; if (done_o !== 4'b0010) begin n_fail++; $display("FAIL mid_first: got %b want 0010", done_o); end
    req_i[1] = 1'b0;
    wait_done(8, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL mid_second_timeout: got none want done"); end
    n_cmp++; if (done_o !== 4'b1000) begin n_fail++; $display("FAIL mid_second: got %b want 1000", done_o); end
    req_i = '0;
    step();
  endtask

  initial begin
    HRESETn     = 1'b0;
    req_i       = '0;
    req_write_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_size_i  = '0;
    HRDATA      = '0;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_round_robin();
    test_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
